// File: rtl/riscv_trace_capture.sv
// riscv_trace_capture: per-core retire FIFOs, round-robin arbitration, one registered valid/ready record per cycle.
// Optional macro RISCV_TRACE_TIMESTAMP_EN adds a free-running cycle stamp stored per entry and shown on timestamp_o.
module riscv_trace_capture #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             c0_retire_valid_i,
  input  logic [31:0]      c0_retire_pc_i,
  input  logic [31:0]      c0_retire_opcode_i,
  input  logic             c1_retire_valid_i,
  input  logic [31:0]      c1_retire_pc_i,
  input  logic [31:0]      c1_retire_opcode_i,
  output logic             valid_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      opcode_o,
  output logic             core_o,
`ifdef RISCV_TRACE_TIMESTAMP_EN
  output logic [31:0]      timestamp_o,
`endif
  input  logic             ready_i,
  output logic [CNT_W-1:0] c0_drop_cnt_o,
  output logic [CNT_W-1:0] c1_drop_cnt_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef RISCV_TRACE_TIMESTAMP_EN
  localparam int RW = 96;
`else
  localparam int RW = 64;
`endif

  logic [RW-1:0]    mem      [2][DEPTH];
  logic [AW-1:0]    wr_ptr   [2];
  logic [AW-1:0]    rd_ptr   [2];
  logic [CW-1:0]    count    [2];
  logic [CNT_W-1:0] drop_cnt [2];
  logic [RW-1:0]    push_rec [2];
  logic [1:0]       push_vld;
  logic [1:0]       non_empty;
  logic [1:0]       pop;
  logic [1:0]       accept;
  logic [1:0]       drop;
  logic             load;
  logic             tie;
  logic             last_grant;
  logic             sel_core;
  logic [RW-1:0]    sel_rec;

`ifdef RISCV_TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 32'd1;
  end
`endif

  always_comb begin
    push_vld = {c1_retire_valid_i, c0_retire_valid_i};
`ifdef RISCV_TRACE_TIMESTAMP_EN
    push_rec[0] = {ts_cnt, c0_retire_opcode_i, c0_retire_pc_i};
    push_rec[1] = {ts_cnt, c1_retire_opcode_i, c1_retire_pc_i};
`else
    push_rec[0] = {c0_retire_opcode_i, c0_retire_pc_i};
    push_rec[1] = {c1_retire_opcode_i, c1_retire_pc_i};
`endif
  end

  // last_grant == 1 means core 0 wins the next tie, so reset favours core 0.
  always_comb begin
    load      = !valid_o || ready_i;
    non_empty = {count[1] != '0, count[0] != '0};
    tie       = load && !flush_i && (non_empty == 2'b11);
    pop       = 2'b00;
    if (load && !flush_i) begin
      unique case (non_empty)
        2'b01:   pop = 2'b01;
        2'b10:   pop = 2'b10;
        2'b11:   pop = last_grant ? 2'b01 : 2'b10;
        default: pop = 2'b00;
      endcase
    end
    for (int i = 0; i < 2; i++) begin
      accept[i] = !flush_i && push_vld[i] && ((count[i] != FULL) || pop[i]);
      drop[i]   = !flush_i && push_vld[i] && !accept[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= push_rec[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i]   <= '0;
        rd_ptr[i]   <= '0;
        count[i]    <= '0;
        drop_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush_i) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
        end else begin
          if (accept[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
          if (pop[i])    rd_ptr[i] <= rd_ptr[i] + AW'(1);
          unique case ({accept[i], pop[i]})
            2'b10:   count[i] <= count[i] + CW'(1);
            2'b01:   count[i] <= count[i] - CW'(1);
            default: count[i] <= count[i];
          endcase
        end
        // Drop counters survive flush and saturate instead of wrapping.
        if (drop[i] && (drop_cnt[i] != {CNT_W{1'b1}})) drop_cnt[i] <= drop_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign sel_core = pop[1];
  assign sel_rec  = mem[sel_core][rd_ptr[sel_core]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o     <= 1'b0;
      pc_o        <= '0;
      opcode_o    <= '0;
      core_o      <= 1'b0;
      last_grant  <= 1'b1;
`ifdef RISCV_TRACE_TIMESTAMP_EN
      timestamp_o <= '0;
`endif
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (load) begin
      valid_o <= |pop;
      if (|pop) begin
        pc_o        <= sel_rec[31:0];
        opcode_o    <= sel_rec[63:32];
        core_o      <= sel_core;
`ifdef RISCV_TRACE_TIMESTAMP_EN
        timestamp_o <= sel_rec[95:64];
`endif
      end
      if (tie) last_grant <= pop[1];
    end
  end

  assign c0_drop_cnt_o = drop_cnt[0];
  assign c1_drop_cnt_o = drop_cnt[1];

endmodule

// File: doc/riscv_trace_capture.md
Name: riscv_trace_capture

Overview:
- Sits directly upstream of the instruction trace monitor.
- Captures retired instructions (PC, opcode) from both cores of the dual-core cluster into per-core FIFOs.
- Arbitrates round-robin between the cores and presents one registered retire record per cycle on a valid/ready interface.
- The trace monitor's valid/pc/opcode inputs are driven from this block's outputs.

Parameters:
- DEPTH, 8, entries per core FIFO; power of two, 2..64.
- CNT_W, 16, width of each saturating drop counter.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset: asynchronous assert, active-low.
- flush_i  input  1  synchronous clear of FIFOs and output stage.
- c0_retire_valid_i  input  1  core 0 retired an instruction this cycle.
- c0_retire_pc_i  input  32  core 0 retired PC.
- c0_retire_opcode_i  input  32  core 0 retired opcode.
- c1_retire_valid_i  input  1  core 1 retired an instruction this cycle.
- c1_retire_pc_i  input  32  core 1 retired PC.
- c1_retire_opcode_i  input  32  core 1 retired opcode.
- valid_o  output  1  record valid (feeds the monitor's valid).
- pc_o  output  32  record PC.
- opcode_o  output  32  record opcode.
- core_o  output  1  source core of the record.
- ready_i  input  1  consumer accepts the record; tie to 1 for the trace monitor.
- c0_drop_cnt_o  output  CNT_W  core 0 records dropped on overflow.
- c1_drop_cnt_o  output  CNT_W  core 1 records dropped on overflow.

Behaviour:
- Reset (rst_ni low, asynchronous): all outputs 0, FIFO pointers and counts 0, last_grant = 1 (so core 0 wins the first tie).
- Per-core FIFO: registered storage; no fall-through.
- Push accepted when retire_valid is 1 and either (count < DEPTH) or that FIFO pops in the same cycle.
- Otherwise the record is dropped and the drop counter increments, saturating at all-ones (never wraps).
- Output stage load condition: output register loads when (valid_o == 0 || ready_i == 1).
- Arbiter choice when loading:
  - only one FIFO non-empty: that FIFO pops.
  - both non-empty: the core != last_grant pops, and last_grant is updated.
  - both empty: valid_o clears on the load edge.
- Handshake: while valid_o = 1 and ready_i = 0, pc_o, opcode_o and core_o hold stable.
- Latency: retire_valid sampled at edge N with empty FIFOs and idle output gives valid_o = 1 after edge N+1 (2 cycles).
- Throughput: one record per cycle while ready_i = 1; records from each core stay in retire order.
- flush_i (synchronous):
  - empties both FIFOs and clears valid_o.
  - a retire arriving in the same cycle is discarded and not counted as a drop.
  - drop counters are preserved; only reset clears them.
- Simultaneous retire on both cores: both pushed in the same cycle, independently.
- Pointers: log2(DEPTH) bits, wrap naturally. Count: log2(DEPTH)+1 bits.
- Reset asserted mid-transfer: all state clears immediately and any in-flight record is lost.

Optional Feature:
- Macro: RISCV_TRACE_TIMESTAMP_EN.
- Defined:
  - a free-running 32-bit cycle counter is added (reset 0, increments every clk_i, wraps).
  - its value is stored with each pushed record and presented on an extra output timestamp_o [31:0], with the same hold rules as pc_o.
  - the field is stored per FIFO entry.
- Undefined: no counter, no timestamp storage, no timestamp_o port.

Test Plan:
- Single retire: c0 valid with pc=0x80000000, opcode=0x00000013, ready_i=1 -> 2 cycles later valid_o=1, pc_o=0x80000000, opcode_o=0x00000013, core_o=0 for exactly 1 cycle.
- Tie arbitration: both cores retire every cycle for 4 cycles (c0 pc 0x100,0x104,0x108,0x10C; c1 pc 0x200,...) -> output alternates core 0,1,0,1,... starting with core 0, per-core order preserved, 8 records total.
- Backpressure/overflow: ready_i=0, DEPTH=8, core 0 retires 12 records -> one record held at output, 8 records in FIFO, 3 dropped so c0_drop_cnt_o=3; after ready_i=1 the 9 records drain in order.
- Saturation: with CNT_W=4, force 20 drops -> c0_drop_cnt_o stops at 0xF.
- Flush: 5 records queued, then flush_i=1 with a concurrent c1 retire -> next cycle valid_o=0, FIFOs empty, drop counters unchanged.
- Async reset mid-stream: pull rst_ni low between edges -> valid_o=0 and drop counters=0 immediately; with RISCV_TRACE_TIMESTAMP_EN defined, the first post-reset record carries the timestamp of its push cycle.
